// File: rtl/csr_regfile.sv
// LoongArch CSR file: mode/exception state, SAVE scratch, TID, timer and interrupt pending.
// Optional timer (TCFG/TVAL/TICLR) is built only when CSR_TIMER_EN is defined.
module csr_regfile #(
  parameter int unsigned SAVE_NUM   = 4,
  parameter int unsigned TIMER_W    = 32,
  parameter int unsigned HW_INT_NUM = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  csr_re,
  input  logic [13:0]           csr_num,
  output logic [31:0]           csr_rvalue,
  input  logic                  csr_we,
  input  logic [31:0]           csr_wmask,
  input  logic [31:0]           csr_wvalue,
  input  logic                  wb_ex,
  input  logic                  ertn_flush,
  input  logic [31:0]           wb_pc,
  input  logic [31:0]           wb_vaddr,
  input  logic [5:0]            wb_ecode,
  input  logic [8:0]            wb_esubcode,
  input  logic [HW_INT_NUM-1:0] hw_int_in,
  input  logic                  ipi_int_in,
  input  logic [31:0]           core_id,
  output logic [31:0]           ex_entry,
  output logic [31:0]           ertn_entry,
  output logic                  has_int
);

  localparam logic [13:0] AddrCrmd   = 14'h00;
  localparam logic [13:0] AddrPrmd   = 14'h01;
  localparam logic [13:0] AddrEcfg   = 14'h04;
  localparam logic [13:0] AddrEstat  = 14'h05;
  localparam logic [13:0] AddrEra    = 14'h06;
  localparam logic [13:0] AddrBadv   = 14'h07;
  localparam logic [13:0] AddrEentry = 14'h0c;
  localparam logic [13:0] AddrTid    = 14'h40;
  localparam logic [13:0] AddrTcfg   = 14'h41;
  localparam logic [13:0] AddrTval   = 14'h42;
  localparam logic [13:0] AddrTiclr  = 14'h44;

  // SWI, TI, IPI always; HWI only for implemented lines; bit 10 never.
  localparam logic [12:0] LieMask = 13'h1803 | 13'(((1 << HW_INT_NUM) - 1) << 2);

  logic [1:0]            plv_q, plv_d, pplv_q, pplv_d;
  logic                  ie_q, ie_d, pie_q, pie_d;
  logic [12:0]           lie_q, lie_d;
  logic [1:0]            swi_q, swi_d;
  logic [HW_INT_NUM-1:0] hwi_q;
  logic                  ipi_q;
  logic [5:0]            ecode_q, ecode_d;
  logic [8:0]            esub_q, esub_d;
  logic [31:0]           era_q, era_d, badv_q, badv_d, tid_q, tid_d;
  logic [25:0]           eentry_q, eentry_d;
  logic [31:0]           save_q [SAVE_NUM];
  logic [31:0]           save_d [SAVE_NUM];
  logic                  has_int_q, has_int_d;
  logic                  timer_flag;
  logic [7:0]            hwi_ext;
  logic [12:0]           is_vec;
  logic [31:0]           wnew, wkeep;

`ifdef CSR_TIMER_EN
  logic [TIMER_W-1:0] tcfg_q, tcfg_d, tval_q, tval_d;
  logic               tflag_q, tflag_d;
  assign timer_flag = tflag_q;
`else
  assign timer_flag = 1'b0;
`endif

  assign wnew  = csr_wmask & csr_wvalue;
  assign wkeep = ~csr_wmask;

  always_comb begin
    hwi_ext = '0;
    hwi_ext[HW_INT_NUM-1:0] = hwi_q;
    is_vec = {ipi_q, timer_flag, 1'b0, hwi_ext, swi_q};
  end

  always_comb begin
    plv_d     = plv_q;
    ie_d      = ie_q;
    pplv_d    = pplv_q;
    pie_d     = pie_q;
    era_d     = era_q;
    badv_d    = badv_q;
    ecode_d   = ecode_q;
    esub_d    = esub_q;
    lie_d     = lie_q;
    swi_d     = swi_q;
    eentry_d  = eentry_q;
    tid_d     = tid_q;
    save_d    = save_q;
    has_int_d = ie_q & |(is_vec & lie_q);

    if (wb_ex) begin
      plv_d   = 2'b00;
      ie_d    = 1'b0;
      pplv_d  = plv_q;
      pie_d   = ie_q;
      era_d   = wb_pc;
      ecode_d = wb_ecode;
      esub_d  = wb_esubcode;
      if (wb_ecode == 6'h08 || wb_ecode == 6'h09) badv_d = wb_vaddr;
    end else begin
      if (ertn_flush) begin
        plv_d = pplv_q;
        ie_d  = pie_q;
      end else if (csr_we && csr_num == AddrCrmd) begin
        plv_d = wnew[1:0] | (wkeep[1:0] & plv_q);
        ie_d  = wnew[2] | (wkeep[2] & ie_q);
      end
      if (csr_we && csr_num == AddrPrmd) begin
        pplv_d = wnew[1:0] | (wkeep[1:0] & pplv_q);
        pie_d  = wnew[2] | (wkeep[2] & pie_q);
      end
      if (csr_we && csr_num == AddrEra) era_d = wnew | (wkeep & era_q);
    end

    if (csr_we) begin
      if (csr_num == AddrEcfg)   lie_d = (wnew[12:0] | (wkeep[12:0] & lie_q)) & LieMask;
      if (csr_num == AddrEstat)  swi_d = wnew[1:0] | (wkeep[1:0] & swi_q);
      if (csr_num == AddrEentry) eentry_d = wnew[31:6] | (wkeep[31:6] & eentry_q);
      if (csr_num == AddrTid)    tid_d = wnew | (wkeep & tid_q);
      for (int i = 0; i < SAVE_NUM; i++) begin
        if (csr_num == 14'(32'h30 + i)) save_d[i] = wnew | (wkeep & save_q[i]);
      end
    end
  end

`ifdef CSR_TIMER_EN
  always_comb begin
    tcfg_d  = tcfg_q;
    tval_d  = tval_q;
    tflag_d = tflag_q;
    if (csr_we && csr_num == AddrTiclr && wnew[0]) tflag_d = 1'b0;
    if (csr_we && csr_num == AddrTcfg) begin
      tcfg_d = wnew[TIMER_W-1:0] | (wkeep[TIMER_W-1:0] & tcfg_q);
      tval_d = {tcfg_d[TIMER_W-1:2], 2'b00};
    end else if (tcfg_q[0]) begin
      if (tval_q != '0) begin
        tval_d = tval_q - TIMER_W'(1);
      end else begin
        // Expiry overrides a same-cycle TICLR clear.
        tflag_d = 1'b1;
        if (tcfg_q[1]) tval_d = {tcfg_q[TIMER_W-1:2], 2'b00};
        else           tcfg_d[0] = 1'b0;
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      plv_q     <= '0;
      ie_q      <= 1'b0;
      pplv_q    <= '0;
      pie_q     <= 1'b0;
      lie_q     <= '0;
      swi_q     <= '0;
      hwi_q     <= '0;
      ipi_q     <= 1'b0;
      ecode_q   <= '0;
      esub_q    <= '0;
      era_q     <= '0;
      badv_q    <= '0;
      eentry_q  <= '0;
      tid_q     <= core_id;
      has_int_q <= 1'b0;
      for (int i = 0; i < SAVE_NUM; i++) save_q[i] <= '0;
`ifdef CSR_TIMER_EN
      tcfg_q    <= '0;
      tval_q    <= '0;
      tflag_q   <= 1'b0;
`endif
    end else begin
      plv_q     <= plv_d;
      ie_q      <= ie_d;
      pplv_q    <= pplv_d;
      pie_q     <= pie_d;
      lie_q     <= lie_d;
      swi_q     <= swi_d;
      hwi_q     <= hw_int_in;
      ipi_q     <= ipi_int_in;
      ecode_q   <= ecode_d;
      esub_q    <= esub_d;
      era_q     <= era_d;
      badv_q    <= badv_d;
      eentry_q  <= eentry_d;
      tid_q     <= tid_d;
      has_int_q <= has_int_d;
      for (int i = 0; i < SAVE_NUM; i++) save_q[i] <= save_d[i];
`ifdef CSR_TIMER_EN
      tcfg_q    <= tcfg_d;
      tval_q    <= tval_d;
      tflag_q   <= tflag_d;
`endif
    end
  end

  always_comb begin
    csr_rvalue = '0;
    if (csr_re) begin
      case (csr_num)
        AddrCrmd:   csr_rvalue = {28'b0, 1'b1, ie_q, plv_q};
        AddrPrmd:   csr_rvalue = {29'b0, pie_q, pplv_q};
        AddrEcfg:   csr_rvalue = {19'b0, lie_q};
        AddrEstat:  csr_rvalue = {1'b0, esub_q, ecode_q, 3'b0, is_vec};
        AddrEra:    csr_rvalue = era_q;
        AddrBadv:   csr_rvalue = badv_q;
        AddrEentry: csr_rvalue = {eentry_q, 6'b0};
        AddrTid:    csr_rvalue = tid_q;
`ifdef CSR_TIMER_EN
        AddrTcfg:   csr_rvalue = 32'(tcfg_q);
        AddrTval:   csr_rvalue = 32'(tval_q);
`endif
        default: begin
          for (int i = 0; i < SAVE_NUM; i++) begin
            if (csr_num == 14'(32'h30 + i)) csr_rvalue = save_q[i];
          end
        end
      endcase
    end
  end

  assign ex_entry   = {eentry_q, 6'b0};
  assign ertn_entry = era_q;
  assign has_int    = has_int_q;

endmodule
